// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM states, channel encoding and timing limits.
// Used by both the receive and transmit I2S controllers.
package i2s_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int I2S_DEFAULT_WIDTH = 16;

    // Minimum clk periods for each BCLK high/low phase so the edge detector sees it.
    localparam int I2S_MIN_CLK_PER_PHASE = 3;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a previous-value flop for rise detection.
// Latency: sync is 2 clk behind the pin; rise is a combinational one-cycle pulse off sync; no backpressure.
module i2s_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S stereo deserialiser: oversamples BCLK/WS/SD with clk and emits left/right pairs.
// Frame appears the cycle after the closing BCLK rise; held until out_ready, overwritten (overrun) if not taken.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH    = I2S_DEFAULT_WIDTH,
    parameter int MAX_SLOT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2s_bclk,
    input  logic                  i2s_ws,
    input  logic                  i2s_sd,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  locked
);

    localparam int CNT_W = $clog2(MAX_SLOT_BITS + 1);

    logic bclk_s;
    logic bclk_rise;
    logic ws_s;
    logic ws_rise;
    logic sd_s;
    logic sd_rise;

    i2s_sync_edge u_sync_bclk (.clk(clk), .reset(reset), .din(i2s_bclk), .sync(bclk_s), .rise(bclk_rise));
    i2s_sync_edge u_sync_ws   (.clk(clk), .reset(reset), .din(i2s_ws),   .sync(ws_s),   .rise(ws_rise));
    i2s_sync_edge u_sync_sd   (.clk(clk), .reset(reset), .din(i2s_sd),   .sync(sd_s),   .rise(sd_rise));

    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] cur_word;
    logic                  ws_last;
    logic                  ws_change;

    i2s_state_t            state_q;
    i2s_state_t            state_d;
    logic                  locked_d;
    logic [DATA_WIDTH-1:0] left_hold_q;
    logic [DATA_WIDTH-1:0] left_hold_d;
    logic                  frame_done;

    assign ws_change = bclk_rise && (ws_s != ws_last);

    // Current word including this cycle's bit; bits past DATA_WIDTH never match and fall away.
    always_comb begin
        cur_word = shift_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1 - i)) begin
                cur_word[i] = sd_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            shift_q <= '0;
            ws_last <= 1'b0;
        end else if (bclk_rise) begin
            if (ws_change) begin
                bit_cnt <= '0;
                shift_q <= '0;
                ws_last <= ws_s;
            end else begin
                shift_q <= cur_word;
                if (bit_cnt != CNT_W'(MAX_SLOT_BITS)) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        locked_d    = locked;
        left_hold_d = left_hold_q;
        frame_done  = 1'b0;
        if (ws_change) begin
            if (bit_cnt < CNT_W'(2)) begin
                // A word this short means WS glitched: drop alignment and any half frame.
                state_d     = SYNC;
                locked_d    = 1'b0;
                left_hold_d = '0;
            end else begin
                unique case (state_q)
                    SYNC: begin
                        if (ws_s == CH_LEFT) begin
                            state_d  = LEFT;
                            locked_d = 1'b1;
                        end
                    end
                    LEFT: begin
                        if (ws_s == CH_RIGHT) begin
                            left_hold_d = cur_word;
                            state_d     = RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (ws_s == CH_LEFT) begin
                            frame_done = 1'b1;
                            state_d    = LEFT;
                        end
                    end
                    default: state_d = SYNC;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            locked      <= 1'b0;
            left_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            locked      <= locked_d;
            left_hold_q <= left_hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_data  <= '0;
            right_data <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                left_data  <= left_hold_q;
                right_data <= cur_word;
                out_valid  <= 1'b1;
                overrun    <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomised bench for i2s_receiver: scenario driver pushes expected frames, a monitor pops them on each transfer.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        i2s_bclk;
    logic        i2s_ws;
    logic        i2s_sd;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        locked;

    int          checks = 0;
    int          errors = 0;
    int          ovr_total = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    i2s_receiver #(.DATA_WIDTH(16), .MAX_SLOT_BITS(32)) dut (
        .clk(clk),
        .reset(reset),
        .i2s_bclk(i2s_bclk),
        .i2s_ws(i2s_ws),
        .i2s_sd(i2s_sd),
        .left_data(left_data),
        .right_data(right_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun(overrun),
        .locked(locked)
    );

    // Monitor: every accepted frame must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame got %h_%h with nothing expected", left_data, right_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({left_data, right_data} !== e) begin
                    errors++;
                    $display("FAIL frame_data got %h_%h want %h_%h", left_data, right_data, e[31:16], e[15:0]);
                end
            end
        end
        if (!reset && overrun) ovr_total++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One BCLK period at clk/16; WS and SD change on the falling edge.
    task automatic send_bit(input logic w, input logic d);
        i2s_bclk = 1'b0;
        i2s_ws   = w;
        i2s_sd   = d;
        tick(8);
        i2s_bclk = 1'b1;
        tick(8);
    endtask

    // MSB first; WS already shows the next channel during the LSB.
    task automatic send_word(input logic ch, input logic [31:0] d, input int nbits, input logic nxt);
        for (int b = nbits - 1; b >= 0; b--) begin
            send_bit((b == 0) ? nxt : ch, d[b]);
        end
    endtask

    function automatic logic [31:0] trunc(input logic [31:0] d, input int n);
        logic [31:0] t;
        if (n >= 16) t = d >> (n - 16);
        else         t = d << (16 - n);
        return t & 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] rnd(input int n);
        logic [31:0] m;
        m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return $urandom() & m;
    endfunction

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits, input bit expect_out);
        logic [31:0] tl;
        logic [31:0] tr;
        tl = trunc(l, nbits);
        tr = trunc(r, nbits);
        if (expect_out) exp_q.push_back({tl[15:0], tr[15:0]});
        send_word(1'b0, l, nbits, 1'b1);
        send_word(1'b1, r, nbits, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d frames outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input int n);
        i2s_bclk = 1'b0;
        reset    = 1'b1;
        tick(n);
        reset    = 1'b0;
        tick(2);
    endtask

    initial begin
        int ovr_base;
        int nb;
        reset     = 1'b1;
        i2s_bclk  = 1'b0;
        i2s_ws    = 1'b0;
        i2s_sd    = 1'b0;
        out_ready = 1'b1;
        tick(4);
        chk("rst_valid",   32'(out_valid),  32'd0);
        chk("rst_locked",  32'(locked),     32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        chk("rst_left",    32'(left_data),  32'd0);
        chk("rst_right",   32'(right_data), 32'd0);
        reset = 1'b0;
        tick(2);

        // Partial left word before lock is discarded; lock at the first WS 1->0.
        send_word(1'b0, rnd(5), 5, 1'b1);
        chk("locked_before_sync", 32'(locked), 32'd0);
        send_word(1'b1, rnd(16), 16, 1'b0);
        chk("locked_after_sync", 32'(locked), 32'd1);
        repeat (3) send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
        drain("fixed_frames");

        // Stream picked up mid-right-word after reset.
        do_reset(3);
        send_word(1'b1, rnd(9), 9, 1'b0);
        chk("locked_mid_right", 32'(locked), 32'd1);
        send_frame(rnd(16), rnd(16), 16, 1'b1);
        drain("mid_right_start");

        // Backpressure: second frame overwrites the first and flags overrun.
        out_ready = 1'b0;
        ovr_base  = ovr_total;
        send_frame(32'h0001, 32'h0002, 16, 1'b0);
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_data", {left_data, right_data}, 32'h0001_0002);
        chk("no_overrun_yet", 32'(ovr_total - ovr_base), 32'd0);
        send_frame(32'h0003, 32'h0004, 16, 1'b1);
        chk("overrun_once", 32'(ovr_total - ovr_base), 32'd1);
        chk("overrun_valid", 32'(out_valid), 32'd1);
        chk("overrun_data", {left_data, right_data}, 32'h0003_0004);
        out_ready = 1'b1;
        drain("overrun");
        tick(2);
        chk("valid_dropped", 32'(out_valid), 32'd0);

        // Slot lengths other than DATA_WIDTH.
        send_frame(32'hABCDEF, 32'hABCDEF, 24, 1'b1);
        send_frame(rnd(24), rnd(24), 24, 1'b1);
        send_frame(32'h7F, 32'h7F, 8, 1'b1);
        send_frame(rnd(8), rnd(8), 8, 1'b1);
        send_frame(rnd(32), rnd(32), 32, 1'b1);
        for (int k = 0; k < 4; k++) begin
            nb = $urandom_range(32, 3);
            send_frame(rnd(nb), rnd(nb), nb, 1'b1);
        end
        drain("slot_widths");

        // WS glitch one bit into the left word drops alignment.
        chk("locked_pre_glitch", 32'(locked), 32'd1);
        send_word(1'b0, rnd(6), 6, 1'b1);
        send_bit(1'b0, 1'($urandom()));
        chk("locked_glitch", 32'(locked), 32'd0);
        send_word(1'b0, rnd(10), 10, 1'b1);
        chk("locked_still_sync", 32'(locked), 32'd0);
        send_word(1'b1, rnd(16), 16, 1'b0);
        chk("locked_relock", 32'(locked), 32'd1);
        send_frame(rnd(16), rnd(16), 16, 1'b1);
        send_frame(rnd(16), rnd(16), 16, 1'b1);
        drain("glitch_recover");

        // Reset mid-right-word while a frame is pending.
        out_ready = 1'b0;
        send_frame(rnd(16), rnd(16), 16, 1'b0);
        chk("pending_valid", 32'(out_valid), 32'd1);
        send_word(1'b0, rnd(16), 16, 1'b1);
        for (int k = 0; k < 8; k++) send_bit(1'b1, 1'($urandom()));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_valid",  32'(out_valid),  32'd0);
        chk("midrst_locked", 32'(locked),     32'd0);
        chk("midrst_data",   {left_data, right_data}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) send_bit(1'b1, 1'($urandom()));
        send_bit(1'b0, 1'($urandom()));
        chk("midrst_relock", 32'(locked), 32'd1);
        send_frame(rnd(16), rnd(16), 16, 1'b1);
        send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
        drain("after_reset");

        chk("overrun_total", 32'(ovr_total), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
